// File: rtl/sipo_piso_master_pkg.sv
// Shared configuration for the serial register-access link: default widths,
// slave memory depth and the frame FSM state encoding.
package sipo_piso_master_pkg;

  localparam int DEF_REG_WIDTH  = 32;
  localparam int MEM_DEPTH      = 10;
  localparam int DEF_ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int DEF_TURNAROUND = 2;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    SHIFT_OUT,
    TURN,
    SHIFT_IN,
    DONE
  } state_e;

  // Bit counter must reach the longest frame phase (data + address bits).
  function automatic int cnt_width(input int reg_w, input int addr_w);
    return $clog2(reg_w + addr_w + 1);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, LSB-first shifter shared by the transmit and receive phases;
// serial input enters at the MSB end so received words land in the top bits.
module serial_shift_reg #(
  parameter int WIDTH    = 36,
  parameter int RX_WIDTH = 32
) (
  input  logic                clk,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_data,
  input  logic                shift_en,
  input  logic                ser_in,
  output logic                ser_out,
  output logic [RX_WIDTH-1:0] rx_next
);

  logic [WIDTH-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (load) begin
      sh_q <= load_data;
    end else if (shift_en) begin
      sh_q <= {ser_in, sh_q[WIDTH-1:1]};
    end
  end

  assign ser_out = sh_q[0];

  // Received word as it will stand after the current shift, so the final
  // sample can be committed on the same edge it is taken.
  assign rx_next = {ser_in, sh_q[WIDTH-1:WIDTH-RX_WIDTH+1]};

endmodule

// File: rtl/sipo_piso_master.sv
// Serial register-access initiator: turns one parallel read/write request into
// a strobe/wr_en/din frame and collects the returned dout stream for reads.
module sipo_piso_master
  import sipo_piso_master_pkg::*;
#(
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  busy,
  output logic                  ser_strobe,
  output logic                  ser_wr_en,
  output logic                  ser_din,
  input  logic                  ser_dout
);

  localparam int SH_W  = REG_WIDTH + ADDR_WIDTH;
  localparam int CNT_W = cnt_width(REG_WIDTH, ADDR_WIDTH);

  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(SH_W - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic [CNT_W-1:0] IN_LAST   = CNT_W'(REG_WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic                 accept;
  logic [SH_W-1:0]      load_data;
  logic                 sh_load, sh_shift, sh_in, sh_out;
  logic [REG_WIDTH-1:0] rx_next;
  logic                 ready_d, valid_d, rwrite_d, busy_d;
  logic                 strobe_d, wren_d, din_d, rdata_upd;

  assign accept = (state_q == IDLE) && req_ready && req_valid;

  // Write frames carry data then address; read frames carry address only.
  assign load_data = req_write ? {req_addr, req_wdata}
                               : {{REG_WIDTH{1'b0}}, req_addr};

  serial_shift_reg #(
    .WIDTH    (SH_W),
    .RX_WIDTH (REG_WIDTH)
  ) u_shift (
    .clk       (clk),
    .load      (sh_load),
    .load_data (load_data),
    .shift_en  (sh_shift),
    .ser_in    (sh_in),
    .ser_out   (sh_out),
    .rx_next   (rx_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = STROBE;
      STROBE:    state_d = SHIFT_OUT;
      SHIFT_OUT: begin
        if (cnt_q == (wr_q ? WR_LAST : RD_LAST)) begin
          if (wr_q) begin
            state_d = DONE;
          end else if (TURNAROUND > 0) begin
            state_d = TURN;
          end else begin
            state_d = SHIFT_IN;
          end
        end
      end
      TURN:      if (cnt_q == TURN_LAST) state_d = SHIFT_IN;
      SHIFT_IN:  if (cnt_q == IN_LAST) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every output is a flop that
  // lines up with the state it describes.
  always_comb begin
    cnt_d     = '0;
    wr_d      = accept ? req_write : wr_q;
    strobe_d  = (state_d == STROBE);
    wren_d    = wr_d && ((state_d == STROBE) || (state_d == SHIFT_OUT));
    din_d     = (state_d == SHIFT_OUT) && sh_out;
    busy_d    = (state_d != IDLE);
    ready_d   = (state_d == IDLE);
    valid_d   = (state_d == DONE);
    rwrite_d  = (state_d == DONE) && wr_q;
    rdata_upd = (state_q == SHIFT_IN) && (state_d == DONE);
    sh_load   = accept;
    sh_shift  = (state_d == SHIFT_OUT) || (state_q == SHIFT_IN);
    sh_in     = (state_q == SHIFT_IN) && ser_dout;
    if ((state_d == state_q) &&
        ((state_q == SHIFT_OUT) || (state_q == TURN) || (state_q == SHIFT_IN))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
      ser_strobe <= 1'b0;
      ser_wr_en  <= 1'b0;
      ser_din    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      req_ready  <= ready_d;
      rsp_valid  <= valid_d;
      rsp_write  <= rwrite_d;
      busy       <= busy_d;
      ser_strobe <= strobe_d;
      ser_wr_en  <= wren_d;
      ser_din    <= din_d;
      if (rdata_upd) begin
        rsp_rdata <= rx_next;
      end
    end
  end

endmodule

// File: tb/tb_sipo_piso_master.sv
// Self-checking bench for sipo_piso_master: drives requests, plays the slave
// side of the link and checks every cycle of each frame against a timeline model.
module tb_sipo_piso_master;
  import sipo_piso_master_pkg::*;

  localparam int RW   = DEF_REG_WIDTH;
  localparam int AW   = DEF_ADDR_WIDTH;
  localparam int TA   = DEF_TURNAROUND;
  localparam int NREC = 100;

  typedef struct packed {
    logic strobe;
    logic wr_en;
    logic din;
    logic busy;
    logic valid;
    logic ready;
    logic rwrite;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [RW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_write;
  logic [RW-1:0] rsp_rdata;
  logic          busy;
  logic          ser_strobe;
  logic          ser_wr_en;
  logic          ser_din;
  logic          ser_dout = 1'b0;

  int            vectors = 0;
  int            miscompares = 0;
  logic [RW-1:0] last_rdata = '0;
  ctl_t          obs_ctl   [0:NREC];
  logic [RW-1:0] obs_rdata [0:NREC];
  logic          drv_dout  [0:NREC];

  sipo_piso_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .ser_strobe (ser_strobe),
    .ser_wr_en  (ser_wr_en),
    .ser_din    (ser_din),
    .ser_dout   (ser_dout)
  );

  always #5 clk = ~clk;

  // Cycle offset (from acceptance) of the completion pulse.
  function automatic int done_at(input bit wr);
    return wr ? 2 + RW + AW : 2 + AW + TA + RW;
  endfunction

  // Expected control outputs n cycles after acceptance, from the frame timeline.
  function automatic ctl_t exp_out(input bit wr, input logic [AW-1:0] addr,
                                   input logic [RW-1:0] wdata, input int n);
    ctl_t e;
    int   nbits;
    int   i;
    nbits = wr ? RW + AW : AW;
    i = n - 2;
    e = '0;
    e.strobe = (n == 1);
    e.wr_en  = wr && (n >= 1) && (n <= 1 + nbits);
    if (i >= 0 && i < nbits) begin
      if (wr && i < RW) e.din = wdata[i];
      else if (wr)      e.din = addr[i - RW];
      else              e.din = addr[i];
    end
    e.busy   = (n >= 1) && (n <= done_at(wr));
    e.valid  = (n == done_at(wr));
    e.ready  = (n > done_at(wr));
    e.rwrite = (n == done_at(wr)) && wr;
    return e;
  endfunction

  // rsp_write is only meaningful alongside rsp_valid.
  function automatic ctl_t mask_rw(input ctl_t o, input ctl_t e);
    ctl_t r;
    r = o;
    if (!e.valid) r.rwrite = 1'b0;
    return r;
  endfunction

  task automatic start_req(input bit wr, input logic [AW-1:0] addr,
                           input logic [RW-1:0] wdata, input logic [RW-1:0] sdata);
    int waited;
    for (int n = 0; n <= NREC; n++) drv_dout[n] = 1'b0;
    if (!wr) for (int k = 0; k < RW; k++) drv_dout[2 + AW + TA + k] = sdata[k];
    waited = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait: req_ready=%b after %0d cycles, required 1", req_ready, waited);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    ser_dout  = 1'b0;
  endtask

  task automatic record(input int ncyc, input int rst_at, input bit scramble,
                        input int valid_until);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      obs_ctl[n]   = {ser_strobe, ser_wr_en, ser_din, busy, rsp_valid, req_ready, rsp_write};
      obs_rdata[n] = rsp_rdata;
      req_valid = (n < valid_until);
      if (n == 1 && valid_until > 1) req_write = 1'b0;
      if (scramble) begin
        req_addr  = AW'($urandom);
        req_wdata = RW'($urandom);
      end
      rst      = (n == rst_at);
      ser_dout = drv_dout[n];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = AW'($urandom);
    req_wdata = RW'($urandom);
    ser_dout  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vectors++;
      if ({ser_strobe, ser_wr_en, ser_din, busy, rsp_valid, req_ready, rsp_write} !== 7'b0 ||
          rsp_rdata !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: ctl=%b rdata=%h, required all zero",
                 {ser_strobe, ser_wr_en, ser_din, busy, rsp_valid, req_ready, rsp_write}, rsp_rdata);
      end
    end
    rst = 1'b0;
    req_valid = 1'b0;
    ser_dout = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: req_ready=%b busy=%b, required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_write(input logic [AW-1:0] addr, input logic [RW-1:0] wdata,
                            input bit scramble);
    ctl_t e, got;
    start_req(1'b1, addr, wdata, '0);
    record(45, 0, scramble, 1);
    for (int n = 1; n <= 45; n++) begin
      e = exp_out(1'b1, addr, wdata, n);
      got = mask_rw(obs_ctl[n], e);
      vectors++;
      if (got !== e || obs_rdata[n] !== last_rdata) begin
        miscompares++;
        $display("FAIL write a=%0d n=%0d: got ctl=%b rdata=%h, required ctl=%b rdata=%h",
                 addr, n, got, obs_rdata[n], e, last_rdata);
      end
    end
  endtask

  task automatic test_read(input logic [AW-1:0] addr, input logic [RW-1:0] sdata,
                           input bit scramble);
    ctl_t          e, got;
    logic [RW-1:0] er;
    start_req(1'b0, addr, RW'($urandom), sdata);
    record(45, 0, scramble, 1);
    for (int n = 1; n <= 45; n++) begin
      e = exp_out(1'b0, addr, '0, n);
      got = mask_rw(obs_ctl[n], e);
      er = (n >= done_at(1'b0)) ? sdata : last_rdata;
      vectors++;
      if (got !== e || obs_rdata[n] !== er) begin
        miscompares++;
        $display("FAIL read a=%0d n=%0d: got ctl=%b rdata=%h, required ctl=%b rdata=%h",
                 addr, n, got, obs_rdata[n], e, er);
      end
    end
    last_rdata = sdata;
  endtask

  task automatic test_back_to_back(input logic [RW-1:0] wdata);
    ctl_t          e, got;
    logic [RW-1:0] er;
    int            t2;
    t2 = done_at(1'b1) + 1;
    start_req(1'b1, AW'(1), wdata, '0);
    // Loopback slave: the second (read) frame returns what the first wrote.
    for (int k = 0; k < RW; k++) drv_dout[t2 + 2 + AW + TA + k] = wdata[k];
    record(82, 0, 1'b0, t2 + done_at(1'b0));
    for (int n = 1; n <= 82; n++) begin
      if (n <= t2) e = exp_out(1'b1, AW'(1), wdata, n);
      else         e = exp_out(1'b0, AW'(1), '0, n - t2);
      got = mask_rw(obs_ctl[n], e);
      er = (n >= t2 + done_at(1'b0)) ? wdata : last_rdata;
      vectors++;
      if (got !== e || obs_rdata[n] !== er) begin
        miscompares++;
        $display("FAIL back_to_back n=%0d: got ctl=%b rdata=%h, required ctl=%b rdata=%h",
                 n, got, obs_rdata[n], e, er);
      end
    end
    last_rdata = wdata;
  endtask

  task automatic test_reset_mid();
    ctl_t          e;
    logic [RW-1:0] er;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
    a = AW'($urandom_range(0, MEM_DEPTH - 1));
    d = RW'($urandom);
    start_req(1'b1, a, d, '0);
    // rst is high during the cycle that carries data bit 10.
    record(45, 12, 1'b0, 1);
    for (int n = 1; n <= 45; n++) begin
      if (n <= 12) begin
        e = exp_out(1'b1, a, d, n);
      end else begin
        e = '0;
        e.ready = (n > 13);
      end
      er = (n <= 12) ? last_rdata : '0;
      vectors++;
      if (mask_rw(obs_ctl[n], e) !== e || obs_rdata[n] !== er) begin
        miscompares++;
        $display("FAIL reset_mid n=%0d: got ctl=%b rdata=%h, required ctl=%b rdata=%h",
                 n, obs_ctl[n], obs_rdata[n], e, er);
      end
    end
    last_rdata = '0;
    test_write(a, RW'($urandom), 1'b0);
    test_read(a, RW'($urandom), 1'b0);
  endtask

  task automatic test_stability();
    test_write(AW'($urandom), RW'($urandom), 1'b1);
    test_read(AW'($urandom), RW'($urandom), 1'b1);
  endtask

  task automatic test_out_of_range();
    test_read(AW'(12), RW'($urandom), 1'b0);
    test_write(AW'(15), RW'($urandom), 1'b0);
    test_read(AW'(10), RW'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_write(AW'(3), 32'hA5A5_0F0F, 1'b0);
    for (int i = 0; i < 4; i++) test_write(AW'($urandom_range(0, MEM_DEPTH - 1)), RW'($urandom), 1'b0);
    test_read(AW'(9), 32'h3D1D_2400, 1'b0);
    for (int i = 0; i < 4; i++) test_read(AW'($urandom_range(0, MEM_DEPTH - 1)), RW'($urandom), 1'b0);
    test_back_to_back(RW'($urandom));
    test_reset_mid();
    test_stability();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
